// File: rtl/wb_bram_burst.sv
// Wishbone B4 RAM slave with byte lanes, CTI/BTE incrementing bursts and error on out-of-range.
// Latency: single = 1 wait state, burst = 1 beat/clk after entry; no master wait states inside a burst.
module wb_bram_burst #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o
);
    localparam int OFF_W = $clog2(SELECT_WIDTH);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [2:0] CTI_INC = 3'b010;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        r_ack, r_err;
    logic [DATA_WIDTH-1:0]       r_dat;
    logic [MEM_ADDR_WIDTH-1:0]   r_ptr;
    logic [1:0]                  r_bte;
    logic [DATA_WIDTH-1:0]       r_mem [DEPTH];

    logic [MEM_ADDR_WIDTH-1:0]   w_word, w_wrap_mask, w_ptr_inc, w_ptr_nxt;
    logic [MEM_ADDR_WIDTH-1:0]   w_wr_addr, w_rd_addr;
    logic                        w_oor, w_req, w_ack_nxt, w_err_nxt;
    logic                        w_wr_en, w_rd_en, w_bte_ld;
    logic                        w_unused;

    assign w_word   = adr_i[MEM_ADDR_WIDTH+OFF_W-1:OFF_W];
    assign w_oor    = |(adr_i >> (MEM_ADDR_WIDTH + OFF_W));
    assign w_req    = cyc_i & stb_i & ~r_ack & ~r_err;
    assign w_unused = ^adr_i;

    // Wrap bursts only advance the low log2(N) bits; linear advances the whole index.
    always_comb begin
        w_wrap_mask = '1;
        case (r_bte)
            2'b01:   w_wrap_mask = MEM_ADDR_WIDTH'(3);
            2'b10:   w_wrap_mask = MEM_ADDR_WIDTH'(7);
            2'b11:   w_wrap_mask = MEM_ADDR_WIDTH'(15);
            default: w_wrap_mask = '1;
        endcase
    end

    assign w_ptr_inc = (r_ptr & ~w_wrap_mask) | ((r_ptr + MEM_ADDR_WIDTH'(1)) & w_wrap_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_bte_ld    = 1'b0;
        w_wr_addr   = w_word;
        w_rd_addr   = w_word;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_oor) begin
                        w_err_nxt = 1'b1;
                    end else if (cti_i == CTI_INC) begin
                        w_rd_en     = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_ptr_nxt   = w_word;
                        w_bte_ld    = 1'b1;
                        w_state_nxt = S_BURST;
                    end else begin
                        w_wr_en   = we_i;
                        w_rd_en   = 1'b1;
                        w_ack_nxt = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (cyc_i & stb_i & r_ack) begin
                    w_wr_en   = we_i;
                    w_wr_addr = r_ptr;
                    w_rd_en   = 1'b1;
                    w_rd_addr = w_ptr_inc;
                    w_ptr_nxt = w_ptr_inc;
                    if (cti_i == CTI_INC) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_ptr <= '0;
            r_bte <= '0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_err_nxt;
            r_ptr <= w_ptr_nxt;
            if (w_bte_ld) r_bte <= bte_i;
            if (w_rd_en)  r_dat <= r_mem[w_rd_addr];
        end
    end

    // Gated by rst_n so a beat caught by reset mid-cycle never lands in memory.
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            for (int i = 0; i < SELECT_WIDTH; i++) begin
                if (sel_i[i]) r_mem[w_wr_addr][8*i +: 8] <= dat_i[8*i +: 8];
            end
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Scoreboard bench for wb_bram_burst: read data queued at drive time, compared on each read ack.
module tb_wb_bram_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] adr_i;
    logic [31:0] dat_i, dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i, cyc_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic        ack_o, err_o;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] b_dat[4];
    logic [31:0] b_exp[4];

    always #5 clk = ~clk;

    wb_bram_burst dut (
        .clk   (clk),
        .rst_n (rst_n),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .sel_i (sel_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .ack_o (ack_o),
        .err_o (err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Every read ack pops the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack_o === 1'b1 && cyc_i && !we_i) begin
            check("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("rd_dat", dat_o, mon_exp);
            end
        end
    end

    task automatic single(input logic [11:0] a, input logic we, input logic [3:0] s,
                          input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        adr_i = a; we_i = we; sel_i = s; dat_i = d;
        cti_i = 3'b000; bte_i = 2'b00; cyc_i = 1'b1; stb_i = 1'b1;
        if (!we && !exp_err) exp_q.push_back(exp_rd);
        @(negedge clk);
        check("sgl_early", {ack_o, err_o}, 2'b00);
        @(negedge clk);
        check("sgl_ack", ack_o, !exp_err);
        check("sgl_err", err_o, exp_err);
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        check("sgl_one_cycle", {ack_o, err_o}, 2'b00);
    endtask

    task automatic burst(input logic [11:0] a, input logic we, input logic [1:0] bte, input int n);
        @(posedge clk); #1;
        adr_i = a; we_i = we; sel_i = 4'hF; dat_i = b_dat[0];
        cti_i = 3'b010; bte_i = bte; cyc_i = 1'b1; stb_i = 1'b1;
        if (!we) for (int k = 0; k < n; k++) exp_q.push_back(b_exp[k]);
        @(negedge clk);
        check("bst_early", ack_o, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("bst_ack", ack_o, 1);
            check("bst_err", err_o, 0);
            @(posedge clk); #1;
            if (k + 1 < n) begin
                dat_i = b_dat[k+1];
                cti_i = (k + 1 == n - 1) ? 3'b111 : 3'b010;
            end else begin
                cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
            end
        end
        @(negedge clk);
        check("bst_done", ack_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0;
        stb_i = 1'b0; cyc_i = 1'b0; cti_i = '0; bte_i = '0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        check("rst_dat", dat_o, 0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Full-word write/read, then a single-lane merge.
        single(12'h040, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        single(12'h040, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
        single(12'h040, 1'b1, 4'h4, 32'h00AA0000, 1'b0, 32'h0);
        single(12'h040, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEAABEEF);

        // Linear read burst crossing the top of memory.
        single(12'h3F8, 1'b1, 4'hF, 32'd1, 1'b0, 32'h0);
        single(12'h3FC, 1'b1, 4'hF, 32'd2, 1'b0, 32'h0);
        single(12'h000, 1'b1, 4'hF, 32'd3, 1'b0, 32'h0);
        single(12'h004, 1'b1, 4'hF, 32'd4, 1'b0, 32'h0);
        b_exp[0] = 32'd1; b_exp[1] = 32'd2; b_exp[2] = 32'd3; b_exp[3] = 32'd4;
        burst(12'h3F8, 1'b0, 2'b00, 4);

        // wrap4 write burst from word 6; word 8 must stay intact.
        single(12'h020, 1'b1, 4'hF, 32'h88888888, 1'b0, 32'h0);
        b_dat[0] = 32'hAAAA0001; b_dat[1] = 32'hBBBB0002;
        b_dat[2] = 32'hCCCC0003; b_dat[3] = 32'hDDDD0004;
        burst(12'h018, 1'b1, 2'b01, 4);
        single(12'h018, 1'b0, 4'hF, 32'h0, 1'b0, 32'hAAAA0001);
        single(12'h01C, 1'b0, 4'hF, 32'h0, 1'b0, 32'hBBBB0002);
        single(12'h010, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCCCC0003);
        single(12'h014, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDDDD0004);
        single(12'h020, 1'b0, 4'hF, 32'h0, 1'b0, 32'h88888888);

        // Out-of-range write: error only, word 0 (the alias) and dat_o untouched.
        single(12'h000, 1'b0, 4'hF, 32'h0, 1'b0, 32'd3);
        single(12'h800, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0);
        check("err_dat_hold", dat_o, 32'd3);
        single(12'h000, 1'b0, 4'hF, 32'h0, 1'b0, 32'd3);

        // Reset during beat 2 of a 4-beat linear write burst.
        for (int k = 0; k < 4; k++)
            single(12'h080 + 12'(4 * k), 1'b1, 4'hF, 32'h11110000 + k, 1'b0, 32'h0);
        @(posedge clk); #1;
        adr_i = 12'h080; we_i = 1'b1; sel_i = 4'hF; dat_i = 32'hA0;
        cti_i = 3'b010; bte_i = 2'b00; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 dat_i = 32'hA1;
        @(posedge clk); #1 dat_i = 32'hA2;
        check("rst_pre_ack", ack_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ack", ack_o, 0);
        check("rst_async_dat", dat_o, 0);
        check("rst_async_err", err_o, 0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        single(12'h080, 1'b0, 4'hF, 32'h0, 1'b0, 32'hA0);
        single(12'h084, 1'b0, 4'hF, 32'h0, 1'b0, 32'hA1);
        single(12'h088, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11110002);
        single(12'h08C, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11110003);

        repeat (2) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
